// File: rtl/conv_scale_sched.sv
`default_nettype none
//==============================================================================
// Module      : conv_scale_sched
// Description : Time-multiplexes one CONV 11x11 Gaussian engine across
//               NUM_SCALES kernel sets per window and tags each result with
//               its scale index. Optional out_en cross-check enabled by
//               defining CONV_SCHED_ERRCHK_EN.
// Revision    : 1.0 - initial release
//==============================================================================
module conv_scale_sched #(
    parameter int NUM_SCALES = 6,
    parameter int CONV_LAT   = 4,
    parameter int DW         = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sched_en,
    input  logic          win_valid,
    output logic          win_ready,
    output logic          conv_en,
    output logic [2:0]    kern_sel,
    input  logic [DW-1:0] conv_dout,
    input  logic          conv_out_en,
    output logic          res_valid,
    output logic [DW-1:0] res_data,
    output logic [2:0]    res_scale,
    output logic          res_last,
    output logic [15:0]   win_cnt,
    output logic          busy,
    output logic          err
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_FLUSH = 2'd2;

    localparam logic [2:0] c_LAST = 3'(NUM_SCALES - 1);

    logic [1:0]                r_state;
    logic [1:0]                w_state_nxt;
    logic [2:0]                r_cnt;
    logic [CONV_LAT-1:0]       r_tag_vld;
    logic [CONV_LAT-1:0][2:0]  r_tag_scale;
    logic [CONV_LAT-1:0]       w_tag_vld_nxt;
    logic [CONV_LAT-1:0][2:0]  w_tag_scale_nxt;
    logic                      r_res_valid;
    logic [DW-1:0]             r_res_data;
    logic [2:0]                r_res_scale;
    logic                      r_res_last;
    logic [15:0]               r_win_cnt;

    logic                      w_stop;
    logic                      w_issue;
    logic                      w_last_issue;
    logic                      w_tag_vld;
    logic [2:0]                w_tag_scale;
    logic                      w_pipe_empty;
    logic                      w_capture;

    // A cleared sched_en only stops at a window boundary, and no new window
    // may start in that boundary cycle.
    assign w_stop       = !sched_en && (r_cnt == 3'd0);
    assign w_issue      = (r_state == c_RUN) && win_valid && !w_stop;
    assign w_last_issue = w_issue && (r_cnt == c_LAST);

    assign w_tag_vld    = r_tag_vld[CONV_LAT-1];
    assign w_tag_scale  = r_tag_scale[CONV_LAT-1];
    assign w_pipe_empty = ~|r_tag_vld;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (sched_en) begin
                    w_state_nxt = c_RUN;
                end
            end
            c_RUN: begin
                if (w_stop) begin
                    w_state_nxt = c_FLUSH;
                end
            end
            c_FLUSH: begin
                if (sched_en) begin
                    w_state_nxt = c_RUN;
                end else if (w_pipe_empty) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    generate
        if (CONV_LAT == 1) begin : g_tag_lat1
            assign w_tag_vld_nxt   = w_issue;
            assign w_tag_scale_nxt = r_cnt;
        end else begin : g_tag_latn
            assign w_tag_vld_nxt   = {r_tag_vld[CONV_LAT-2:0], w_issue};
            assign w_tag_scale_nxt = {r_tag_scale[CONV_LAT-2:0], r_cnt};
        end
    endgenerate

`ifdef CONV_SCHED_ERRCHK_EN
    logic r_err;

    assign w_capture = w_tag_vld && conv_out_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (conv_out_en != w_tag_vld) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    logic w_unused_conv_out_en;

    assign w_unused_conv_out_en = conv_out_en;
    assign w_capture            = w_tag_vld;
    assign err                  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_cnt       <= 3'd0;
            r_tag_vld   <= '0;
            r_tag_scale <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_scale <= 3'd0;
            r_res_last  <= 1'b0;
            r_win_cnt   <= 16'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_tag_vld   <= w_tag_vld_nxt;
            r_tag_scale <= w_tag_scale_nxt;
            r_res_valid <= w_capture;
            if (w_issue) begin
                r_cnt <= w_last_issue ? 3'd0 : r_cnt + 3'd1;
            end
            if (w_capture) begin
                r_res_data  <= conv_dout;
                r_res_scale <= w_tag_scale;
                r_res_last  <= (w_tag_scale == c_LAST);
            end
            if (w_last_issue) begin
                r_win_cnt <= r_win_cnt + 16'd1;
            end
        end
    end

    assign conv_en   = w_issue;
    assign win_ready = w_last_issue;
    assign kern_sel  = r_cnt;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_scale = r_res_scale;
    assign res_last  = r_res_last;
    assign win_cnt   = r_win_cnt;
    assign busy      = (r_state != c_IDLE) || !w_pipe_empty;

endmodule
`default_nettype wire

// File: tb/tb_conv_scale_sched.sv
`default_nettype none
//==============================================================================
// Module      : tb_conv_scale_sched
// Description : Directed bench for conv_scale_sched with a 4-cycle CONV stub
//               (dout = 0x100 + kern_sel).
// Revision    : 1.0 - initial release
//==============================================================================
module tb_conv_scale_sched;

    localparam int NS = 6;

    logic        clk;
    logic        rst;
    logic        sched_en;
    logic        win_valid;
    logic        win_ready;
    logic        conv_en;
    logic [2:0]  kern_sel;
    logic [17:0] conv_dout;
    logic        conv_out_en;
    logic        res_valid;
    logic [17:0] res_data;
    logic [2:0]  res_scale;
    logic        res_last;
    logic [15:0] win_cnt;
    logic        busy;
    logic        err;

    logic            spur = 1'b0;
    logic [3:0]      s_vld = '0;
    logic [3:0][2:0] s_ks = '0;

    int total = 0;
    int bad   = 0;

    conv_scale_sched #(.NUM_SCALES(6), .CONV_LAT(4), .DW(18)) dut (
        .clk(clk), .rst(rst), .sched_en(sched_en), .win_valid(win_valid),
        .win_ready(win_ready), .conv_en(conv_en), .kern_sel(kern_sel),
        .conv_dout(conv_dout), .conv_out_en(conv_out_en),
        .res_valid(res_valid), .res_data(res_data), .res_scale(res_scale),
        .res_last(res_last), .win_cnt(win_cnt), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CONV stub: fixed 4-cycle latency, not affected by the scheduler reset
    always @(posedge clk) begin
        s_vld <= {s_vld[2:0], conv_en};
        s_ks  <= {s_ks[2:0], kern_sel};
    end
    assign conv_out_en = s_vld[3] | spur;
    assign conv_dout   = 18'h100 + {15'd0, s_ks[3]};

    typedef struct packed {
        logic        se;
        logic        wv;
        logic        ce;
        logic [2:0]  ks;
        logic        wr;
        logic        rv;
        logic [2:0]  rs;
        logic [17:0] rd;
        logic        rl;
        logic        bz;
        logic [15:0] wc;
    } vec_t;

    function automatic vec_t mk(input logic se, input logic wv, input logic ce,
                                input logic [2:0] ks, input logic wr, input logic rv,
                                input logic [2:0] rs, input logic [17:0] rd,
                                input logic rl, input logic bz, input logic [15:0] wc);
        vec_t v;
        v = '{se, wv, ce, ks, wr, rv, rs, rd, rl, bz, wc};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic        ce_log [64];
    logic [2:0]  ks_log [64];
    logic        rv_log [64];
    logic [2:0]  rs_log [64];
    logic [17:0] rd_log [64];
    logic        rl_log [64];
    logic        bz_log [64];

    task automatic run(input int n, input logic [63:0] se_p, input logic [63:0] wv_p);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            sched_en  = se_p[i];
            win_valid = wv_p[i];
            @(negedge clk);
            ce_log[i] = conv_en;
            ks_log[i] = kern_sel;
            rv_log[i] = res_valid;
            rs_log[i] = res_scale;
            rd_log[i] = res_data;
            rl_log[i] = res_last;
            bz_log[i] = busy;
        end
    endtask

    int n_iss, iss_first, iss_last, kerr;
    int n_res, res_first, rerr;
    int res_at [64];

    // Issues must cycle 0..NS-1; results must carry matching scale/data/last
    task automatic scan(input int n);
        n_iss = 0; iss_first = -1; iss_last = -1; kerr = 0;
        n_res = 0; res_first = -1; rerr = 0;
        for (int i = 0; i < n; i++) begin
            if (ce_log[i]) begin
                if (int'(ks_log[i]) != n_iss % NS) kerr++;
                if (iss_first < 0) iss_first = i;
                iss_last = i;
                n_iss++;
            end
            if (rv_log[i]) begin
                if (int'(rs_log[i]) != n_res % NS) rerr++;
                if (rd_log[i] != 18'(32'h100 + n_res % NS)) rerr++;
                if (rl_log[i] != ((n_res % NS) == NS - 1)) rerr++;
                if (res_first < 0) res_first = i;
                res_at[n_res] = i;
                n_res++;
            end
        end
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        sched_en  = 1'b0;
        win_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    vec_t tbl [14];

    initial begin
        tbl[0]  = mk(1, 1, 0, 0, 0, 0, 0, 18'h000, 0, 0, 0);
        tbl[1]  = mk(1, 1, 1, 0, 0, 0, 0, 18'h000, 0, 1, 0);
        tbl[2]  = mk(1, 1, 1, 1, 0, 0, 0, 18'h000, 0, 1, 0);
        tbl[3]  = mk(1, 1, 1, 2, 0, 0, 0, 18'h000, 0, 1, 0);
        tbl[4]  = mk(1, 1, 1, 3, 0, 0, 0, 18'h000, 0, 1, 0);
        tbl[5]  = mk(1, 1, 1, 4, 0, 0, 0, 18'h000, 0, 1, 0);
        tbl[6]  = mk(1, 1, 1, 5, 1, 1, 0, 18'h100, 0, 1, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 1, 1, 18'h101, 0, 1, 1);
        tbl[8]  = mk(0, 0, 0, 0, 0, 1, 2, 18'h102, 0, 1, 1);
        tbl[9]  = mk(0, 0, 0, 0, 0, 1, 3, 18'h103, 0, 1, 1);
        tbl[10] = mk(0, 0, 0, 0, 0, 1, 4, 18'h104, 0, 1, 1);
        tbl[11] = mk(0, 0, 0, 0, 0, 1, 5, 18'h105, 1, 1, 1);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 5, 18'h105, 1, 0, 1);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 5, 18'h105, 1, 0, 1);

        rst = 1'b1; sched_en = 1'b0; win_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.conv_en",   32'(conv_en),   0);
        chk("rst.kern_sel",  32'(kern_sel),  0);
        chk("rst.win_ready", 32'(win_ready), 0);
        chk("rst.res_valid", 32'(res_valid), 0);
        chk("rst.res_data",  32'(res_data),  0);
        chk("rst.win_cnt",   32'(win_cnt),   0);
        chk("rst.busy",      32'(busy),      0);
        chk("rst.err",       32'(err),       0);
        #1 rst = 1'b0;

        // Single window, cycle by cycle
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            sched_en  = tbl[i].se;
            win_valid = tbl[i].wv;
            @(negedge clk);
            chk($sformatf("single[%0d].conv_en", i),   32'(conv_en),   32'(tbl[i].ce));
            chk($sformatf("single[%0d].kern_sel", i),  32'(kern_sel),  32'(tbl[i].ks));
            chk($sformatf("single[%0d].win_ready", i), 32'(win_ready), 32'(tbl[i].wr));
            chk($sformatf("single[%0d].res_valid", i), 32'(res_valid), 32'(tbl[i].rv));
            chk($sformatf("single[%0d].res_scale", i), 32'(res_scale), 32'(tbl[i].rs));
            chk($sformatf("single[%0d].res_data", i),  32'(res_data),  32'(tbl[i].rd));
            chk($sformatf("single[%0d].res_last", i),  32'(res_last),  32'(tbl[i].rl));
            chk($sformatf("single[%0d].busy", i),      32'(busy),      32'(tbl[i].bz));
            chk($sformatf("single[%0d].win_cnt", i),   32'(win_cnt),   32'(tbl[i].wc));
        end

        // Three back-to-back windows
        do_reset();
        run(32, 64'h7FFFF, 64'h7FFFF);
        scan(32);
        chk("b2b.issues",     32'(n_iss), 18);
        chk("b2b.issue_span", 32'(iss_last - iss_first + 1), 18);
        chk("b2b.kern_order", 32'(kerr), 0);
        chk("b2b.results",    32'(n_res), 18);
        chk("b2b.res_span",   32'(res_at[17] - res_first + 1), 18);
        chk("b2b.res_order",  32'(rerr), 0);
        chk("b2b.latency",    32'(res_first - iss_first), 5);
        chk("b2b.win_cnt",    32'(win_cnt), 3);
        chk("b2b.busy_end",   32'(bz_log[31]), 0);

        // win_valid gap after scale 2
        do_reset();
        run(24, 64'h1FF, 64'h1CF);
        scan(24);
        chk("gap.conv_en_c4",  32'(ce_log[4]), 0);
        chk("gap.conv_en_c5",  32'(ce_log[5]), 0);
        chk("gap.kern_sel_c4", 32'(ks_log[4]), 3);
        chk("gap.kern_sel_c5", 32'(ks_log[5]), 3);
        chk("gap.issues",      32'(n_iss), 6);
        chk("gap.kern_order",  32'(kerr), 0);
        chk("gap.results",     32'(n_res), 6);
        chk("gap.res_order",   32'(rerr), 0);
        chk("gap.res_first",   32'(res_first), 6);
        chk("gap.res_hole",    32'(res_at[3] - res_at[2]), 3);
        chk("gap.win_cnt",     32'(win_cnt), 1);

        // sched_en cleared at scale 1 while win_valid stays high
        do_reset();
        run(20, 64'h3, 64'hFFFFF);
        scan(20);
        chk("stop.issues",     32'(n_iss), 6);
        chk("stop.last_issue", 32'(iss_last), 6);
        chk("stop.kern_order", 32'(kerr), 0);
        chk("stop.results",    32'(n_res), 6);
        chk("stop.res_order",  32'(rerr), 0);
        chk("stop.busy_c11",   32'(bz_log[11]), 1);
        chk("stop.busy_c12",   32'(bz_log[12]), 0);
        chk("stop.busy_c19",   32'(bz_log[19]), 0);

        // Asynchronous reset mid-window at scale 3
        do_reset();
        run(11, 64'h7FF, 64'h7FF);
        chk("arst.pre_kern_sel", 32'(kern_sel), 3);
        chk("arst.pre_win_cnt",  32'(win_cnt), 1);
        chk("arst.pre_busy",     32'(busy), 1);
        #1 rst = 1'b1;
        #1;
        chk("arst.conv_en",   32'(conv_en),   0);
        chk("arst.kern_sel",  32'(kern_sel),  0);
        chk("arst.win_ready", 32'(win_ready), 0);
        chk("arst.res_valid", 32'(res_valid), 0);
        chk("arst.res_data",  32'(res_data),  0);
        chk("arst.res_scale", 32'(res_scale), 0);
        chk("arst.res_last",  32'(res_last),  0);
        chk("arst.win_cnt",   32'(win_cnt),   0);
        chk("arst.busy",      32'(busy),      0);
        chk("arst.err",       32'(err),       0);
        @(posedge clk);
        #1 rst = 1'b0;
        run(16, 64'hFFFF, 64'hFFFF);
        scan(16);
        chk("arst.restart_en",   32'(ce_log[0]), 1);
        chk("arst.restart_kern", 32'(ks_log[0]), 0);
        chk("arst.kern_order",   32'(kerr), 0);
        chk("arst.res_first",    32'(res_first), 5);
        chk("arst.res_order",    32'(rerr), 0);
        run(24, 64'h0, 64'hFFFFFF);
        chk("arst.drain_busy", 32'(bz_log[23]), 0);

        // Spurious conv_out_en with an empty tag pipe
        do_reset();
        @(negedge clk);
        chk("spur.err_pre", 32'(err), 0);
        @(posedge clk);
        #1 spur = 1'b1;
        @(posedge clk);
        #1 spur = 1'b0;
        @(negedge clk);
        chk("spur.res_valid", 32'(res_valid), 0);
`ifdef CONV_SCHED_ERRCHK_EN
        chk("spur.err_set", 32'(err), 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("spur.err_held", 32'(err), 1);
`else
        chk("spur.err_tied", 32'(err), 0);
`endif
        do_reset();
        @(negedge clk);
        chk("spur.err_cleared", 32'(err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_scale_sched.md
# conv_scale_sched

Scheduler that time-multiplexes one `CONV` 11x11 Gaussian engine across `NUM_SCALES` kernel sets (the SIFT octave scales). For each 11x11 window presented by the line-buffer front end, it issues one `CONV` cycle per scale. It drives the kernel-select mux that feeds `df1_1..df1_11` and tags each `CONV` result with its scale index. It sits between the window generator and the DoG/extrema stage.

## Interface
- `NUM_SCALES`, 6, kernel sets issued per window (2..8)
- `CONV_LAT`, 4, cycles from a `conv_en` issue cycle to the matching `CONV` `out_en` (1..16)
- `DW`, 18, width of `CONV` `dout` / `res_data`
- `clk`  in  1  pixel-domain clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `sched_en`  in  1  run enable; deassert = finish current window, then stop
- `win_valid`  in  1  window on `din1..din11` valid; upstream holds it stable until accepted
- `win_ready`  out  1  window consumed this cycle (`win_valid && win_ready`)
- `conv_en`  out  1  `CONV` issue strobe for this cycle
- `kern_sel`  out  3  kernel-set index driving the coefficient mux
- `conv_dout`  in  DW  `CONV` `dout`
- `conv_out_en`  in  1  `CONV` `out_en`
- `res_valid`  out  1  tagged result valid (no backpressure)
- `res_data`  out  DW  registered `conv_dout`
- `res_scale`  out  3  scale index of `res_data`
- `res_last`  out  1  `res_scale == NUM_SCALES-1`
- `win_cnt`  out  16  count of accepted windows, wraps at 0xFFFF→0
- `busy`  out  1  state != IDLE or tag pipe non-empty
- `err`  out  1  sticky tag/out_en mismatch (see Configuration)

## Operation
- State machine: IDLE, RUN, FLUSH.
  - IDLE→RUN when `sched_en=1`.
  - RUN→FLUSH when `sched_en=0` and `cnt==0` (window boundary).
  - FLUSH→IDLE when the tag pipe is empty.
  - FLUSH→RUN if `sched_en` reasserts.
- `cnt` (3 b) is the scale counter; `kern_sel = cnt` (registered).
- Issue cycle: state RUN and `win_valid=1`.
  - `conv_en = 1` (combinational from state and `win_valid`).
  - `cnt` increments. When `cnt == NUM_SCALES-1`, `cnt` wraps to 0 and `win_ready = 1`.
- If `win_valid` drops mid-window (protocol violation): no issue that cycle, `cnt` holds, a bubble enters the tag pipe.
- `sched_en` deasserted mid-window: the remaining scales of that window are still issued; the stop takes effect only at `cnt==0`.
- Tag pipe: `CONV_LAT`-deep shift register of {valid, scale}. Each cycle it pushes {issue, `cnt`}.
- Result capture: when the pipe output is valid, register `res_data = conv_dout`, `res_scale = tag.scale`, `res_last`, and `res_valid = 1`. Otherwise `res_valid = 0` and the other result outputs hold their value.
- `win_cnt` increments on each handshake.
- Reset (async, any state, including mid-window):
  - `cnt`, tag pipe, state → 0/IDLE.
  - All outputs → 0: `win_ready`, `conv_en`, `kern_sel`, `res_valid`, `res_data`, `res_scale`, `res_last`, `win_cnt`, `busy`, `err`.
  - In-flight `CONV` results arriving after reset are discarded (the tag pipe is empty).

## Timing
- Throughput: one window per `NUM_SCALES` cycles when `win_valid` is continuously high. Back-to-back windows have no gap.
- Latency: issue at cycle t → `conv_out_en` at t+`CONV_LAT` → `res_valid` at t+`CONV_LAT`+1.
- `win_ready` is asserted only in the last issue cycle of a window. The next window may appear on the bus at t+1.
- `kern_sel` changes only on the clock edge that ends an issue cycle, so it is stable throughout each issue cycle.
- `busy` falls no earlier than the cycle after the last `res_valid`.

## Configuration
- `CONV_SCHED_ERRCHK_EN` defined: each cycle, compare `conv_out_en` against the tag-pipe valid bit.
  - Any mismatch sets `err`, which stays set until `rst`.
  - `res_valid` requires both `conv_out_en` and the tag valid bit.
- `CONV_SCHED_ERRCHK_EN` undefined: `err` is tied to 0, `conv_out_en` is ignored, and `res_valid` comes from the tag valid bit alone.

## Test plan
- Single window, defaults, stub `CONV` with `dout = 0x100 + kern_sel` delayed 4 cycles:
  - `conv_en` is high for 6 cycles with `kern_sel` 0..5.
  - `win_ready` pulses in the 6th cycle.
  - `res_valid` is high for 6 cycles starting 5 cycles after the first issue, with `res_data` 0x100..0x105, `res_scale` 0..5, and `res_last` only on scale 5.
- Three back-to-back windows:
  - 18 consecutive issue cycles; `win_cnt` = 3.
  - 18 consecutive `res_valid` cycles with scale sequence 0..5 three times.
- `win_valid` dropped for 2 cycles after scale 2:
  - `cnt` holds at 3 and `conv_en` is 0 during the gap.
  - Results show a 2-cycle `res_valid` gap, with scales still in order 0..5.
- `sched_en` cleared at scale 1:
  - Scales 2..5 are still issued, then FLUSH.
  - `busy` drops after the last result; no further `conv_en`.
- `rst` pulsed mid-window at scale 3:
  - All outputs are 0 immediately (asynchronously).
  - After release with `win_valid` high, the window restarts at `kern_sel = 0`.
- With `CONV_SCHED_ERRCHK_EN`: a spurious `conv_out_en` pulse while the tag pipe is empty → `err = 1` next edge, held until `rst`, and no `res_valid` for that pulse.
